uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1024, idle cycles allowed for a locked requester before forced release (>=2).
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_data  input  8*NUM_REQ  byte of requester k on bits [8k+7:8k].
REQ-006 SHALL have port i_last  input  NUM_REQ  bit k marks requester k's current byte as the final byte of its message.
REQ-007 SHALL have port i_valid  input  NUM_REQ  bit k means requester k offers a byte.
REQ-008 SHALL have port o_ready  output  NUM_REQ  bit k means requester k's byte is accepted this cycle.
REQ-009 SHALL have port o_data  output  8  byte presented to the UART emitter.
REQ-010 SHALL have port o_valid  output  1  o_data is valid toward the emitter.
REQ-011 SHALL have port i_ready  input  1  emitter ready; transfer occurs when o_valid and i_ready are both high.
REQ-012 SHALL have port o_grant  output  NUM_REQ  one-hot current owner, all zero when idle.
REQ-013 SHALL have port o_timeout  output  1  one-cycle pulse when a lock is force-released.

Function
REQ-014 SHALL implement two states: IDLE (no owner) and LOCKED (one owner in o_grant).
REQ-015 In IDLE with any i_valid bit high, SHALL select the winner by round-robin from pointer rr_ptr upward (wrapping from NUM_REQ-1 to 0), register it in o_grant and enter LOCKED the next cycle.
REQ-016 On every grant, SHALL set rr_ptr to (winner+1) mod NUM_REQ.
REQ-017 In IDLE with all i_valid low, SHALL stay in IDLE and leave rr_ptr unchanged.
REQ-018 SHALL drive o_ready[k] = LOCKED & o_grant[k] & (!o_valid | i_ready), combinationally; all other o_ready bits SHALL be 0.
REQ-019 An accept (o_ready[k] & i_valid[k]) SHALL load i_data byte k into o_data and set o_valid on the next edge.
REQ-020 An emitter transfer without a simultaneous accept SHALL clear o_valid on the next edge; a transfer and an accept in the same cycle SHALL leave o_valid high with the new byte (back-to-back, no bubble).
REQ-021 o_data and o_valid SHALL hold stable while o_valid=1 and i_ready=0.
REQ-022 An accept with i_last[k]=1 SHALL return to IDLE on the next edge and clear o_grant; the buffered last byte SHALL still drain normally.
REQ-023 Request-to-accept latency: i_valid rising in IDLE gives o_grant and o_ready one cycle later; o_valid follows one cycle after accept.
REQ-024 In LOCKED, SHALL count consecutive cycles in which the owner holds i_valid low; the counter SHALL reset to 0 on any owner i_valid high and on entering LOCKED.
REQ-025 When the counter reaches TIMEOUT-1, SHALL return to IDLE on the next edge, clear o_grant and pulse o_timeout for exactly that one cycle, without disturbing o_valid/o_data.
REQ-026 Non-owner i_valid bits SHALL be ignored in LOCKED and SHALL not affect rr_ptr.
REQ-027 Requesters SHALL keep i_data/i_last stable while i_valid=1 and o_ready=0; the arbiter SHALL not require i_valid to be held after an accept.

Reset
REQ-028 With i_rst high at a clock edge: state IDLE, o_grant=0, o_valid=0, o_data=8'h00, rr_ptr=0, timeout counter=0, o_timeout=0; o_ready all zero.
REQ-029 Reset mid-message SHALL discard the buffered byte and the lock; the first post-reset arbitration SHALL give requester 0 highest priority.

Verification
REQ-030 Single requester: req1 sends 8'h48,8'h69 (last on 8'h69), i_ready=1 -> grant 4'b0010 one cycle after i_valid, o_data 8'h48 then 8'h69 on consecutive cycles, IDLE after.
REQ-031 Contention: req0 and req2 each send 2-byte messages at the same time after reset -> req0's bytes fully out before any req2 byte, no interleaving; next tie between 0 and 2 won by 2.
REQ-032 Backpressure: i_ready low 868 cycles per byte (emitter pacing) -> o_data stable throughout, each byte emitted exactly once, o_ready[k] high only when buffer empty or draining.
REQ-033 Timeout: TIMEOUT=16, req3 sends 8'hAA without last then idles -> o_timeout pulses once 16 cycles after accept, o_grant=0, waiting req1 granted next cycle.
REQ-034 Reset mid-message: i_rst asserted with o_valid=1 and lock held -> next cycle o_valid=0, o_grant=0, rr_ptr=0; simultaneous requests 0 and 3 -> requester 0 wins.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one byte-stream requester onto a UART emitter
// for a whole message, with a one-byte output buffer and idle-owner timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [8*NUM_REQ-1:0] i_data,
  input  logic [NUM_REQ-1:0]   i_last,
  input  logic [NUM_REQ-1:0]   i_valid,
  output logic [NUM_REQ-1:0]   o_ready,
  output logic [7:0]           o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [7:0]         r_data, w_data_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_timeout, w_timeout_nxt;

  logic               w_owner_valid;
  logic               w_owner_last;
  logic [7:0]         w_owner_data;
  logic               w_accept;
  logic               w_found;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [IW-1:0]      w_win_idx;

  // Owner fields are selected through the one-hot grant so no index register is needed.
  always_comb begin
    w_owner_valid = |(i_valid & r_grant);
    w_owner_last  = |(i_last & r_grant);
    w_owner_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) w_owner_data = w_owner_data | i_data[8*k +: 8];
    end
  end

  assign o_ready  = (r_state == S_LOCKED && (!r_valid || i_ready)) ? r_grant : '0;
  assign w_accept = |(o_ready & i_valid);

  // Scan from the round-robin pointer upward, wrapping, and take the first request.
  always_comb begin
    int unsigned j;
    w_found   = 1'b0;
    w_win_oh  = '0;
    w_win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = i + 32'(r_rr_ptr);
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && i_valid[IW'(j)]) begin
        w_found            = 1'b1;
        w_win_oh[IW'(j)]   = 1'b1;
        w_win_idx          = IW'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_LOCKED;
          w_grant_nxt  = w_win_oh;
          w_rr_ptr_nxt = (w_win_idx == IW'(NUM_REQ-1)) ? '0 : w_win_idx + 1'b1;
          w_cnt_nxt    = '0;
        end
      end
      S_LOCKED: begin
        if (w_owner_valid) begin
          w_cnt_nxt = '0;
          if (w_accept && w_owner_last) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
          end
        end else if (r_cnt == CW'(TIMEOUT-1)) begin
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = '0;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase

    // An accept refills the buffer even when the emitter drains it in the same cycle.
    if (w_accept) begin
      w_data_nxt  = w_owner_data;
      w_valid_nxt = 1'b1;
    end else if (r_valid && i_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_grant   = r_grant;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scripted requester message queues driven against a
// message-level reference model, plus directed scenarios for the corner cases.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int T    = 16;
  localparam int PACE = 868;

  logic           clk = 1'b0;
  logic           rst;
  logic [8*N-1:0] data;
  logic [N-1:0]   last, valid, ready_o, grant;
  logic [7:0]     odata;
  logic           ovalid, iready, oto;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_last(last), .i_valid(valid),
    .o_ready(ready_o), .o_data(odata), .o_valid(ovalid), .i_ready(iready),
    .o_grant(grant), .o_timeout(oto)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner id (-1 = nobody), next-priority id, idle run length, buffer.
  int         m_own = -1, m_ptr = 0, m_cnt = 0;
  bit         m_bv = 0, m_to = 0;
  logic [7:0] m_bd = 8'h00;
  bit         chk_en = 0;

  logic [7:0] qd [N][$];
  bit         ql [N][$];
  int         gap [N];
  bit         rnd_gaps = 0;
  bit         rnd_rst = 0;
  int         ready_mode = 0;
  int         pace = 0;
  logic [7:0] emitted [$];
  int         n_to_seen = 0;

  task automatic step();
    logic [N-1:0] rdy, xg;
    int n_own, n_ptr, n_cnt;
    bit n_bv, n_to, acc, was_last;
    logic [7:0] n_bd;
    if (rnd_rst) rst = ($urandom_range(0, 599) == 0);
    for (int k = 0; k < N; k++) begin
      valid[k] = (qd[k].size() > 0) && (gap[k] == 0);
      if (valid[k]) begin
        data[8*k +: 8] = qd[k][0];
        last[k]        = ql[k][0];
      end else begin
        data[8*k +: 8] = 8'($urandom);
        last[k]        = 1'($urandom);
      end
    end
    case (ready_mode)
      0: iready = 1'b1;
      1: iready = ($urandom_range(0, 3) != 0);
      2: iready = (pace >= PACE);
      default: iready = 1'b0;
    endcase
    #3;
    rdy = '0;
    xg  = '0;
    if (m_own >= 0) begin
      xg[m_own]  = 1'b1;
      rdy[m_own] = !m_bv || iready;
    end
    if (chk_en) begin
      check("grant", grant, xg);
      check("ready", ready_o, rdy);
      check("o_valid", ovalid, m_bv);
      check("o_data", odata, m_bd);
      check("o_timeout", oto, m_to);
    end
    if (oto) n_to_seen++;
    if (m_bv && iready) emitted.push_back(odata);

    n_own = m_own; n_ptr = m_ptr; n_cnt = m_cnt;
    n_bv = m_bv; n_bd = m_bd; n_to = 0;
    acc = (m_own >= 0) && valid[m_own] && rdy[m_own];
    if (rst) begin
      n_own = -1; n_ptr = 0; n_cnt = 0; n_bv = 0; n_bd = 8'h00;
    end else begin
      if (m_own < 0) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (n_own < 0 && valid[k]) begin
            n_own = k; n_ptr = (k + 1) % N; n_cnt = 0;
          end
        end
      end else if (valid[m_own]) begin
        n_cnt = 0;
        if (acc && last[m_own]) n_own = -1;
      end else if (m_cnt == T - 1) begin
        n_own = -1; n_to = 1;
      end else begin
        n_cnt = m_cnt + 1;
      end
      if (acc) begin
        n_bv = 1; n_bd = data[8*m_own +: 8];
      end else if (m_bv && iready) begin
        n_bv = 0;
      end
    end

    for (int k = 0; k < N; k++) begin
      if (valid[k] && rdy[k]) begin
        was_last = ql[k][0];
        void'(qd[k].pop_front());
        void'(ql[k].pop_front());
        if (rnd_gaps)
          gap[k] = was_last ? $urandom_range(0, 3) :
                   (($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 2));
      end
    end
    if (m_bv && iready) pace = 0;
    else if (m_bv) pace++;
    else pace = 0;

    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (!valid[k] && gap[k] > 0) gap[k]--;
    m_own = n_own; m_ptr = n_ptr; m_cnt = n_cnt;
    m_bv = n_bv; m_bd = n_bd; m_to = n_to;
    if (rst) chk_en = 1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) begin
      qd[k].delete(); ql[k].delete(); gap[k] = 0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    emitted.delete();
    n_to_seen = 0;
    pace = 0;
  endtask

  task automatic push(input int k, input logic [7:0] b, input bit l);
    qd[k].push_back(b);
    ql[k].push_back(l);
  endtask

  initial begin
    logic [7:0] exp_c [5];
    logic [7:0] exp_b [3];
    bit done;
    rst = 1'b1; data = '0; last = '0; valid = '0; iready = 1'b0;

    // Single requester, two-byte message
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_valid", ovalid, 0);
    check("rst_data", odata, 8'h00);
    push(1, 8'h48, 0); push(1, 8'h69, 1);
    step();
    check("t1_grant", grant, 4'b0010);
    check("t1_ready", ready_o, 4'b0010);
    step();
    check("t1_b0", {ovalid, odata}, {1'b1, 8'h48});
    step();
    check("t1_b1", {ovalid, odata}, {1'b1, 8'h69});
    check("t1_idle", grant, 0);
    step();
    check("t1_drain", ovalid, 0);

    // Contention between 0 and 2; req0 has a second message queued
    do_reset();
    push(0, 8'h10, 0); push(0, 8'h11, 1); push(0, 8'h12, 1);
    push(2, 8'h20, 0); push(2, 8'h21, 1);
    for (int c = 0; c < 40 && emitted.size() < 5; c++) step();
    exp_c = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12};
    check("t2_count", emitted.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), emitted[i], exp_c[i]);

    // Emitter pacing: long backpressure per byte
    do_reset();
    ready_mode = 2;
    push(1, 8'h11, 0); push(1, 8'h22, 1); push(3, 8'h33, 1);
    for (int c = 0; c < 4000 && emitted.size() < 3; c++) step();
    for (int c = 0; c < 5; c++) step();
    exp_b = '{8'h11, 8'h22, 8'h33};
    check("t3_count", emitted.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("t3_order%0d", i), emitted[i], exp_b[i]);

    // Timeout with the byte held in the buffer
    do_reset();
    ready_mode = 3;
    push(3, 8'hAA, 0);
    step();
    step();
    push(1, 8'h55, 1);
    for (int c = 0; c < 15; c++) step();
    check("t4_pre_grant", grant, 4'b1000);
    check("t4_pre_to", oto, 0);
    step();
    check("t4_to", oto, 1);
    check("t4_grant", grant, 0);
    check("t4_buf", {ovalid, odata}, {1'b1, 8'hAA});
    step();
    check("t4_regrant", grant, 4'b0010);
    check("t4_to_end", oto, 0);
    ready_mode = 0;
    for (int c = 0; c < 6; c++) step();
    check("t4_pulses", n_to_seen, 1);

    // Reset in the middle of a locked message
    do_reset();
    ready_mode = 3;
    push(2, 8'h01, 0); push(2, 8'h02, 0); push(2, 8'h03, 1);
    for (int c = 0; c < 4; c++) step();
    check("t5_pre", {ovalid, grant}, {1'b1, 4'b0100});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", ovalid, 0);
    check("t5_grant", grant, 0);
    qd[2].delete(); ql[2].delete();
    ready_mode = 0;
    push(0, 8'h5A, 1); push(3, 8'hA5, 1);
    step();
    check("t5_winner", grant, 4'b0001);
    for (int c = 0; c < 8; c++) step();

    // Randomized traffic with gaps, random backpressure and occasional resets
    do_reset();
    ready_mode = 1;
    rnd_gaps = 1;
    rnd_rst = 1;
    for (int k = 0; k < N; k++)
      for (int m = 0; m < 8; m++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) push(k, 8'($urandom), b == len - 1);
      end
    done = 0;
    for (int c = 0; c < 8000 && !done; c++) begin
      step();
      done = !m_bv;
      for (int k = 0; k < N; k++) if (qd[k].size() > 0) done = 0;
    end
    rnd_rst = 0;
    rst = 1'b0;
    check("rnd_drained", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
